// File: rtl/writeback_unit_if.sv
// Write-back channel: retiring-instruction fields in, register-file write port
// and status out. master = upstream pipeline, slave = writeback_unit.
interface writeback_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_data;
  logic [31:0] pc;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        reg_dest;
  logic        mem_to_reg;
  logic        jal_signal;
  logic        reg_write;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        flush;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic [31:0] retire_count;

  modport master (
    output in_valid, alu_data, pc, rt, rd, reg_dest, mem_to_reg, jal_signal,
           reg_write, mem_valid, mem_data, flush,
    input  in_ready, wr_en, wr_addr, wr_data, busy, retire_count
  );

  modport slave (
    input  in_valid, alu_data, pc, rt, rd, reg_dest, mem_to_reg, jal_signal,
           reg_write, mem_valid, mem_data, flush,
    output in_ready, wr_en, wr_addr, wr_data, busy, retire_count
  );
endinterface

// File: rtl/writeback_unit.sv
// Register-file write sequencer: resolves destination/data of a retiring
// instruction, waits for late load data, and issues a one-cycle write.
module writeback_unit (
  input  logic             clock,
  input  logic             reset_n,
  writeback_unit_if.slave  wb
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  hold_dest_reg, hold_dest_next;
  logic        hold_we_reg, hold_we_next;
  logic        wr_en_reg, wr_en_next;
  logic [4:0]  wr_addr_reg, wr_addr_next;
  logic [31:0] wr_data_reg, wr_data_next;
  logic [31:0] retire_count_reg, retire_count_next;

  logic        accept;
  logic        in_is_load;
  logic [4:0]  in_dest;
  logic [31:0] in_data;

  // jal overrides both the destination select and the data select.
  always_comb begin
    in_dest = wb.jal_signal ? 5'd31 : (wb.reg_dest ? wb.rd : wb.rt);
    in_data = wb.jal_signal ? (wb.pc + 32'd4)
                            : (wb.mem_to_reg ? wb.mem_data : wb.alu_data);
    in_is_load = wb.reg_write & wb.mem_to_reg & ~wb.jal_signal;
    accept = wb.in_valid & (state_reg == IDLE);
  end

  always_comb begin
    state_next        = state_reg;
    hold_dest_next    = hold_dest_reg;
    hold_we_next      = hold_we_reg;
    wr_en_next        = 1'b0;
    wr_addr_next      = wr_addr_reg;
    wr_data_next      = wr_data_reg;
    retire_count_next = retire_count_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          hold_dest_next = in_dest;
          hold_we_next   = wb.reg_write & (in_dest != 5'd0);
          if (in_is_load) begin
            state_next = WAIT_MEM;
          end else begin
            state_next        = COMMIT;
            wr_en_next        = wb.reg_write & (in_dest != 5'd0);
            wr_addr_next      = in_dest;
            wr_data_next      = in_data;
            retire_count_next = retire_count_reg + 32'd1;
          end
        end
      end
      WAIT_MEM: begin
        // Abort beats a simultaneous data return.
        if (wb.flush) begin
          state_next = IDLE;
        end else if (wb.mem_valid) begin
          state_next        = COMMIT;
          wr_en_next        = hold_we_reg;
          wr_addr_next      = hold_dest_reg;
          wr_data_next      = wb.mem_data;
          retire_count_next = retire_count_reg + 32'd1;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      hold_dest_reg    <= 5'd0;
      hold_we_reg      <= 1'b0;
      wr_en_reg        <= 1'b0;
      wr_addr_reg      <= 5'd0;
      wr_data_reg      <= 32'd0;
      retire_count_reg <= 32'd0;
    end else begin
      state_reg        <= state_next;
      hold_dest_reg    <= hold_dest_next;
      hold_we_reg      <= hold_we_next;
      wr_en_reg        <= wr_en_next;
      wr_addr_reg      <= wr_addr_next;
      wr_data_reg      <= wr_data_next;
      retire_count_reg <= retire_count_next;
    end
  end

  assign wb.in_ready     = (state_reg == IDLE);
  assign wb.busy         = (state_reg != IDLE);
  assign wb.wr_en        = wr_en_reg;
  assign wb.wr_addr      = wr_addr_reg;
  assign wb.wr_data      = wr_data_reg;
  assign wb.retire_count = retire_count_reg;

endmodule
